conv_sched: RTL and testbench
=============================

Name: conv_sched

Overview:
- Job-level sequencer for the convolution datapath: img_ctrl, kernel_ctrl, mult_block, output_ctrl.
- Accepts a job descriptor: number of kernel passes and image beats per pass.
- Per pass, it opens the kernel AXI-Stream for exactly K_DIM beats, then the image stream for exactly the programmed number of beats, then waits for the output stream's last beat before the next pass.
- It sits between the external DMA streams and the datapath stream inputs, and gates valid/ready only; data passes through untouched.

Parameters:
K_DIM, 3, kernel dimension; kernel beats per pass
M_BITS, 16, stream data width (pass-through only)
PASS_W, 8, width of pass counter and job_npass
BEAT_W, 16, width of image beat counter and job_nbeats
DRAIN_TO, 4096, max cycles waiting for out_last before timeout error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
job_valid  in  1  job descriptor valid
job_ready  out  1  high only in IDLE
job_npass  in  PASS_W  number of kernel passes; 0 is illegal
job_nbeats  in  BEAT_W  image beats per pass; 0 is illegal
s_k_valid / s_k_ready / s_k_last  in/out/in  1 each  upstream kernel stream handshake
m_k_valid / m_k_ready / m_k_last  out/in/out  1 each  to kernel_ctrl
s_img_valid / s_img_ready / s_img_last  in/out/in  1 each  upstream image stream handshake
m_img_valid / m_img_ready / m_img_last  out/in/out  1 each  to img_ctrl
out_valid / out_ready / out_last  in/in/in  1 each  monitor of output_ctrl stream (observe only)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at job end
err  out  3  sticky error bits: [0] illegal job, [1] stream last mismatch, [2] drain timeout
pass_idx  out  PASS_W  current pass index

Behaviour:
- Reset: state IDLE, all counters 0; job_ready=1; busy=0, done=0, err=0, pass_idx=0; all gated valid/ready outputs 0.
- States: IDLE, LOAD_K, RUN_IMG, DRAIN, FIN.
- IDLE: on job_valid&job_ready, latch npass/nbeats and clear err.
  - If either field is 0: set err[0], go to FIN.
  - Otherwise go to LOAD_K with pass_idx=0.
- Gating is combinational:
  - m_k_valid = s_k_valid & (state==LOAD_K); s_k_ready = m_k_ready & (state==LOAD_K); m_k_last = s_k_last.
  - The image stream is gated the same way with RUN_IMG.
  - Zero added latency on all gated paths.
- LOAD_K: count kernel handshakes (m_k_valid&m_k_ready).
  - On beat K_DIM: go to RUN_IMG and clear the beat counter.
  - s_k_last asserted on any other beat, or deasserted on beat K_DIM, sets err[1]; the count still governs the transition.
- RUN_IMG: count image handshakes.
  - m_img_last is forced to 1 on beat nbeats, otherwise 0 (upstream last is ignored for output).
  - s_img_last disagreeing with the beat count sets err[1].
  - On beat nbeats: go to DRAIN, reset the timeout counter.
- DRAIN: the timeout counter increments each cycle.
  - On an out_valid&out_ready&out_last handshake: if pass_idx==npass-1 go to FIN, else pass_idx++ and go to LOAD_K.
  - If the counter reaches DRAIN_TO-1 without that handshake: set err[2], go to FIN (abort remaining passes).
- FIN: done=1 for exactly one cycle, then go to IDLE. err holds until the next job is accepted.
- Output handshakes seen outside DRAIN are ignored (no error).
- Simultaneous events:
  - A new job_valid during a non-IDLE state is not accepted (job_ready=0).
  - The timeout and the out_last handshake in the same cycle resolve to success.
- Counters: pass counter PASS_W bits, beat counter BEAT_W bits, timeout counter clog2(DRAIN_TO) bits. No wrap is reachable because comparisons terminate counting first.
- Reset mid-job: immediate return to IDLE; gates close asynchronously; partially transferred streams are not completed.

Decomposition:
- Shared package accel_pkg:
  - state enum sched_state_t.
  - err bit index constants ERR_JOB, ERR_LAST, ERR_TO.
- One natural sub-module: stream_gate. It takes an enable plus valid/ready/last and is instantiated twice (kernel path and image path), with optional last override.
- The FSM and counters stay in conv_sched.

Test Plan:
- npass=2, nbeats=9, K_DIM=3, streams always valid, out_last after 5 cycles in DRAIN:
  - exactly 3 kernel beats then 9 image beats per pass;
  - m_img_last on beats 9 and 18;
  - pass_idx 0 then 1;
  - done pulses once; err=0.
- job_npass=0 -> err=3'b001, done one cycle after acceptance, no stream handshakes occur.
- nbeats=4 with upstream s_img_last on beat 3 -> m_img_last only on beat 4, err[1]=1, job completes normally.
- DRAIN_TO=16, out_last never arrives -> err[2] set on the 16th DRAIN cycle, done pulses, remaining passes skipped.
- m_k_ready toggled 1,0,1,0: kernel counter advances only on handshake cycles; s_k_ready mirrors m_k_ready in LOAD_K and is 0 in all other states.
- Assert rst during RUN_IMG at beat 5 -> same cycle: m_img_valid=0, busy=0, job_ready=1 after release; a new job starts at pass 0.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types and constants for the convolution job sequencer.
//   sched_state_t : sequencer FSM states
//   ERR_*         : bit positions inside the sticky err vector
package accel_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_K  = 3'd1,
    S_RUN_IMG = 3'd2,
    S_DRAIN   = 3'd3,
    S_FIN     = 3'd4
  } sched_state_t;

  localparam int unsigned ERR_W    = 3;
  localparam int unsigned ERR_JOB  = 0;
  localparam int unsigned ERR_LAST = 1;
  localparam int unsigned ERR_TO   = 2;

endpackage

// File: rtl/stream_gate.sv
// Combinational AXI-Stream valid/ready gate with optional last override.
// Ports:
//   en_i                      : opens the gate
//   s_valid_i/s_ready_o/s_last_i : upstream side
//   m_valid_o/m_ready_i/m_last_o : downstream side
//   last_ovr_en_i/last_ovr_i  : replace upstream last with last_ovr_i
//   hs_o                      : a beat transfers this cycle
module stream_gate (
  input  logic en_i,
  input  logic s_valid_i,
  output logic s_ready_o,
  input  logic s_last_i,
  output logic m_valid_o,
  input  logic m_ready_i,
  output logic m_last_o,
  input  logic last_ovr_en_i,
  input  logic last_ovr_i,
  output logic hs_o
);

  assign m_valid_o = s_valid_i & en_i;
  assign s_ready_o = m_ready_i & en_i;
  assign m_last_o  = last_ovr_en_i ? last_ovr_i : s_last_i;
  assign hs_o      = s_valid_i & m_ready_i & en_i;

endmodule

// File: rtl/conv_sched.sv
// Job-level sequencer for the convolution datapath. Per pass it opens the
// kernel stream for K_DIM beats, then the image stream for job_nbeats beats,
// then waits for the output stream's last beat (bounded by DRAIN_TO cycles).
// Ports:
//   clk, rst                 : clock, async active-high reset
//   job_valid/job_ready      : job descriptor handshake (ready only in IDLE)
//   job_npass, job_nbeats    : passes per job, image beats per pass
//   s_k_* / m_k_*            : kernel stream, upstream / to kernel_ctrl
//   s_img_* / m_img_*        : image stream, upstream / to img_ctrl
//   out_valid/ready/last     : output_ctrl stream monitor
//   busy, done, err, pass_idx: status
module conv_sched
  import accel_pkg::*;
#(
  parameter int unsigned K_DIM    = 3,
  parameter int unsigned M_BITS   = 16,
  parameter int unsigned PASS_W   = 8,
  parameter int unsigned BEAT_W   = 16,
  parameter int unsigned DRAIN_TO = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [PASS_W-1:0] job_npass,
  input  logic [BEAT_W-1:0] job_nbeats,
  input  logic              s_k_valid,
  output logic              s_k_ready,
  input  logic              s_k_last,
  output logic              m_k_valid,
  input  logic              m_k_ready,
  output logic              m_k_last,
  input  logic              s_img_valid,
  output logic              s_img_ready,
  input  logic              s_img_last,
  output logic              m_img_valid,
  input  logic              m_img_ready,
  output logic              m_img_last,
  input  logic              out_valid,
  input  logic              out_ready,
  input  logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err,
  output logic [PASS_W-1:0] pass_idx
);

  localparam int unsigned TO_W = $clog2(DRAIN_TO);

  // A mis-parameterised instance never accepts a job.
  localparam bit PARAMS_OK = (M_BITS > 0) && (K_DIM > 0) && (PASS_W > 0) &&
                             (BEAT_W > 0) && (DRAIN_TO >= 2);

  sched_state_t      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] npass_q, npass_d;
  logic [BEAT_W-1:0] nbeats_q, nbeats_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic k_hs, img_hs, out_hs;
  logic k_last_beat, img_last_beat;

  assign k_last_beat   = (beat_q == BEAT_W'(K_DIM - 1));
  assign img_last_beat = (beat_q == (nbeats_q - BEAT_W'(1)));
  assign out_hs        = out_valid & out_ready & out_last;

  // Kernel path: upstream last passes through unchanged.
  stream_gate u_k_gate (
    .en_i          (state_q == S_LOAD_K),
    .s_valid_i     (s_k_valid),
    .s_ready_o     (s_k_ready),
    .s_last_i      (s_k_last),
    .m_valid_o     (m_k_valid),
    .m_ready_i     (m_k_ready),
    .m_last_o      (m_k_last),
    .last_ovr_en_i (1'b0),
    .last_ovr_i    (1'b0),
    .hs_o          (k_hs)
  );

  // Image path: last is regenerated from the programmed beat count.
  stream_gate u_img_gate (
    .en_i          (state_q == S_RUN_IMG),
    .s_valid_i     (s_img_valid),
    .s_ready_o     (s_img_ready),
    .s_last_i      (s_img_last),
    .m_valid_o     (m_img_valid),
    .m_ready_i     (m_img_ready),
    .m_last_o      (m_img_last),
    .last_ovr_en_i (1'b1),
    .last_ovr_i    ((state_q == S_RUN_IMG) & img_last_beat),
    .hs_o          (img_hs)
  );

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      to_q     <= '0;
      pass_q   <= '0;
      npass_q  <= '0;
      nbeats_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      to_q     <= to_d;
      pass_q   <= pass_d;
      npass_q  <= npass_d;
      nbeats_q <= nbeats_d;
      err_q    <= err_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    to_d     = to_q;
    pass_d   = pass_q;
    npass_d  = npass_q;
    nbeats_d = nbeats_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (job_valid && PARAMS_OK) begin
          npass_d  = job_npass;
          nbeats_d = job_nbeats;
          err_d    = '0;
          pass_d   = '0;
          beat_d   = '0;
          if ((job_npass == '0) || (job_nbeats == '0)) begin
            err_d[ERR_JOB] = 1'b1;
            state_d        = S_FIN;
          end else begin
            state_d = S_LOAD_K;
          end
        end
      end

      S_LOAD_K: begin
        if (k_hs) begin
          // The beat count, not upstream last, decides the transition.
          if (s_k_last != k_last_beat) err_d[ERR_LAST] = 1'b1;
          if (k_last_beat) begin
            beat_d  = '0;
            state_d = S_RUN_IMG;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      S_RUN_IMG: begin
        if (img_hs) begin
          if (s_img_last != img_last_beat) err_d[ERR_LAST] = 1'b1;
          if (img_last_beat) begin
            beat_d  = '0;
            to_d    = '0;
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      S_DRAIN: begin
        // Output last wins over a timeout in the same cycle.
        if (out_hs) begin
          if (pass_q == (npass_q - PASS_W'(1))) begin
            state_d = S_FIN;
          end else begin
            pass_d  = pass_q + PASS_W'(1);
            state_d = S_LOAD_K;
          end
        end else if (to_q == TO_W'(DRAIN_TO - 1)) begin
          err_d[ERR_TO] = 1'b1;
          state_d       = S_FIN;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign job_ready = (state_q == S_IDLE) && PARAMS_OK;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign err       = err_q;
  assign pass_idx  = pass_q;

endmodule

// File: tb/tb_conv_sched.sv
module tb_conv_sched;

  localparam int unsigned PASS_W = 8;
  localparam int unsigned BEAT_W = 16;

  logic              clk;
  logic              rst;
  logic              job_valid, job_ready;
  logic [PASS_W-1:0] job_npass;
  logic [BEAT_W-1:0] job_nbeats;
  logic s_k_valid, s_k_ready, s_k_last, m_k_valid, m_k_ready, m_k_last;
  logic s_img_valid, s_img_ready, s_img_last, m_img_valid, m_img_ready, m_img_last;
  logic out_valid, out_ready, out_last;
  logic busy, done;
  logic [2:0]        err;
  logic [PASS_W-1:0] pass_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int k_hs = 0, img_hs = 0, nl = 0, done_cnt = 0;
  int last_at [8];
  int kb, ib, lb, db;

  conv_sched #(
    .K_DIM(3), .M_BITS(16), .PASS_W(PASS_W), .BEAT_W(BEAT_W), .DRAIN_TO(16)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_npass(job_npass), .job_nbeats(job_nbeats),
    .s_k_valid(s_k_valid), .s_k_ready(s_k_ready), .s_k_last(s_k_last),
    .m_k_valid(m_k_valid), .m_k_ready(m_k_ready), .m_k_last(m_k_last),
    .s_img_valid(s_img_valid), .s_img_ready(s_img_ready), .s_img_last(s_img_last),
    .m_img_valid(m_img_valid), .m_img_ready(m_img_ready), .m_img_last(m_img_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .err(err), .pass_idx(pass_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_k_valid && m_k_ready) k_hs <= k_hs + 1;
    if (m_img_valid && m_img_ready) begin
      img_hs <= img_hs + 1;
      if (m_img_last && nl < 8) begin
        last_at[nl] <= img_hs + 1;
        nl <= nl + 1;
      end
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int np, input int nb);
    job_npass  = PASS_W'(np);
    job_nbeats = BEAT_W'(nb);
    job_valid  = 1'b1;
    @(negedge clk);
    chk("idle_job_ready", job_ready, 1);
    chk("idle_busy", busy, 0);
    nxt();
    job_valid = 1'b0;
  endtask

  task automatic kpass(input int p);
    for (int k = 1; k <= 3; k++) begin
      s_k_last = (k == 3);
      @(negedge clk);
      chk("k_valid", m_k_valid, 1);
      chk("k_ready", s_k_ready, 1);
      chk("k_last_pass", m_k_last, (k == 3));
      chk("k_img_closed", m_img_valid, 0);
      chk("k_pass_idx", pass_idx, p);
      chk("k_job_ready", job_ready, 0);
      chk("k_err", err, 0);
      nxt();
    end
    s_k_last = 1'b0;
  endtask

  task automatic ipass(input int nb, input int upl);
    for (int b = 1; b <= nb; b++) begin
      s_img_last = (b == upl);
      @(negedge clk);
      chk("img_valid", m_img_valid, 1);
      chk("img_ready", s_img_ready, 1);
      chk("img_last", m_img_last, (b == nb));
      chk("img_k_ready_closed", s_k_ready, 0);
      chk("img_k_valid_closed", m_k_valid, 0);
      nxt();
    end
    s_img_last = 1'b0;
  endtask

  task automatic drain(input int w);
    for (int c = 0; c < w; c++) begin
      out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b0;
      @(negedge clk);
      chk("drain_busy", busy, 1);
      chk("drain_done", done, 0);
      chk("drain_k_ready", s_k_ready, 0);
      chk("drain_img_ready", s_img_ready, 0);
      nxt();
    end
    out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b1;
    @(negedge clk);
    chk("drain_last_busy", busy, 1);
    chk("drain_last_done", done, 0);
    nxt();
    out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
  endtask

  task automatic fin(input logic [2:0] e);
    @(negedge clk);
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 1);
    chk("fin_job_ready", job_ready, 0);
    chk("fin_err", err, e);
    nxt();
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy_low", busy, 0);
    chk("idle_ready", job_ready, 1);
    chk("idle_err_hold", err, e);
    chk("idle_k_ready", s_k_ready, 0);
    nxt();
  endtask

  initial begin
    rst = 1'b1;
    job_valid = 1'b0; job_npass = '0; job_nbeats = '0;
    s_k_valid = 1'b1; m_k_ready = 1'b1; s_k_last = 1'b0;
    s_img_valid = 1'b1; m_img_ready = 1'b1; s_img_last = 1'b0;
    out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pass_idx", pass_idx, 0);
    chk("rst_m_k_valid", m_k_valid, 0);
    chk("rst_s_k_ready", s_k_ready, 0);
    chk("rst_m_img_valid", m_img_valid, 0);
    chk("rst_s_img_ready", s_img_ready, 0);
    rst = 1'b0;
    nxt();

    // Two passes, nine image beats, out_last after five drain cycles.
    kb = k_hs; ib = img_hs; lb = nl; db = done_cnt;
    start(2, 9);
    job_valid = 1'b1; job_npass = '0;
    kpass(0);
    ipass(9, 9);
    job_valid = 1'b0;
    drain(5);
    kpass(1);
    ipass(9, 9);
    drain(5);
    fin(3'b000);
    chk("t1_k_beats", k_hs - kb, 6);
    chk("t1_img_beats", img_hs - ib, 18);
    chk("t1_last_count", nl - lb, 2);
    chk("t1_last_at_0", last_at[lb] - ib, 9);
    chk("t1_last_at_1", last_at[lb + 1] - ib, 18);
    chk("t1_done_pulses", done_cnt - db, 1);

    // Illegal jobs: zero passes, then zero beats.
    kb = k_hs; ib = img_hs;
    start(0, 5);
    fin(3'b001);
    start(1, 0);
    fin(3'b001);
    chk("t2_no_k_beats", k_hs - kb, 0);
    chk("t2_no_img_beats", img_hs - ib, 0);

    // Early upstream image last: regenerated last stays on beat 4.
    ib = img_hs; lb = nl;
    start(1, 4);
    kpass(0);
    ipass(4, 3);
    drain(0);
    fin(3'b010);
    chk("t3_last_count", nl - lb, 1);
    chk("t3_last_at", last_at[lb] - ib, 4);

    // Drain timeout aborts remaining passes; output beats outside drain ignored.
    kb = k_hs;
    start(3, 2);
    out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b1;
    kpass(0);
    out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
    ipass(2, 2);
    for (int c = 1; c <= 16; c++) begin
      out_valid = 1'b1; out_ready = 1'b0; out_last = 1'b1;
      @(negedge clk);
      chk("t4_drain_busy", busy, 1);
      chk("t4_drain_done", done, 0);
      chk("t4_drain_err", err, 0);
      nxt();
    end
    out_valid = 1'b0; out_last = 1'b0;
    fin(3'b100);
    chk("t4_pass_idx", pass_idx, 0);
    nxt();
    nxt();
    chk("t4_k_beats", k_hs - kb, 3);

    // Kernel ready toggling: only handshake cycles advance the count.
    kb = k_hs;
    start(1, 1);
    for (int c = 1; c <= 5; c++) begin
      m_k_ready = (c % 2 == 1);
      s_k_last  = (c == 5);
      @(negedge clk);
      chk("t5_k_valid", m_k_valid, 1);
      chk("t5_k_ready_mirror", s_k_ready, (c % 2 == 1));
      nxt();
      chk("t5_k_count", k_hs - kb, (c + 1) / 2);
    end
    m_k_ready = 1'b1;
    s_k_last  = 1'b0;
    ipass(1, 1);
    drain(1);
    fin(3'b000);

    // Reset in the middle of image beat 5, then a fresh job.
    start(2, 9);
    kpass(0);
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      chk("t6_img_valid", m_img_valid, 1);
      chk("t6_img_last", m_img_last, 0);
      nxt();
    end
    chk("t6_pre_rst_valid", m_img_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_img_valid", m_img_valid, 0);
    chk("t6_rst_img_ready", s_img_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_job_ready", job_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    nxt();
    chk("t6_post_job_ready", job_ready, 1);
    chk("t6_post_pass_idx", pass_idx, 0);
    kb = k_hs; ib = img_hs;
    start(1, 2);
    kpass(0);
    ipass(2, 2);
    drain(1);
    fin(3'b000);
    chk("t6_k_beats", k_hs - kb, 3);
    chk("t6_img_beats", img_hs - ib, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
